// File: rtl/player_bullet.sv
// Single player bullet: launches from the ship centre, climbs one step per frame, then impact/cooldown.
// Optional macro PLAYER_BULLET_AUTOFIRE_EN makes launch level-sensitive on shoot_i.
module player_bullet #(
    parameter int unsigned spawn_y_p         = 440,
    parameter int unsigned top_y_p           = 16,
    parameter int unsigned step_p            = 8,
    parameter int unsigned impact_frames_p   = 4,
    parameter int unsigned cooldown_frames_p = 2,
    parameter logic [11:0] color_p           = 12'b1111_1111_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frame_i,
    input  logic        enable_i,
    input  logic        shoot_i,
    input  logic [9:0]  player_left_i,
    input  logic [9:0]  player_right_i,
    input  logic        hit_i,
    output logic        bullet_active_o,
    output logic        impact_o,
    output logic [9:0]  bullet_x_o,
    output logic [9:0]  bullet_y_o,
    output logic        fired_o,
    output logic [7:0]  shots_o,
    output logic [11:0] color_o,
    output logic [3:0]  state_o
);

    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 10;
    localparam int unsigned CW  = 8;
    localparam int unsigned SW  = 8;

    localparam logic [YW-1:0] SPAWN_Y  = YW'(spawn_y_p);
    localparam logic [YW-1:0] STEP_Y   = YW'(step_p);
    localparam logic [YW-1:0] MISS_Y   = YW'(top_y_p + step_p);
    localparam logic [CW-1:0] IMP_LAST = CW'(impact_frames_p - 1);
    localparam logic [CW-1:0] CD_LAST  = CW'(cooldown_frames_p - 1);
    localparam logic [SW-1:0] SHOT_MAX = {SW{1'b1}};

    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        FLYING   = 4'b0010,
        IMPACT   = 4'b0100,
        COOLDOWN = 4'b1000
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shots_q, shots_d;
    logic            prev_q;
    logic            fired_q, fired_d;
    logic            active_q, active_d;
    logic            impact_q, impact_d;

    logic            launch_c;
    logic [XW:0]     sum_c;

    // Launch trigger: edge-detected button, or plain level when autofire is built in.
`ifdef PLAYER_BULLET_AUTOFIRE_EN
    assign launch_c = shoot_i;
`else
    assign launch_c = shoot_i & ~prev_q;
`endif

    assign sum_c = {1'b0, player_left_i} + {1'b0, player_right_i};

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        shots_d  = shots_q;
        fired_d  = 1'b0;
        active_d = 1'b0;
        impact_d = 1'b0;

        if (!enable_i) begin
            state_d = IDLE;
            y_d     = SPAWN_Y;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch_c) begin
                        state_d = FLYING;
                        x_d     = sum_c[XW:1];
                        y_d     = SPAWN_Y;
                        fired_d = 1'b1;
                        if (shots_q != SHOT_MAX) begin
                            shots_d = shots_q + SW'(1);
                        end
                    end
                end
                FLYING: begin
                    if (hit_i) begin
                        state_d = IMPACT;
                    end else if (frame_i) begin
                        if (y_q < MISS_Y) begin
                            state_d = COOLDOWN;
                        end else begin
                            y_d = y_q - STEP_Y;
                        end
                    end
                end
                IMPACT: begin
                    if (frame_i) begin
                        if (cnt_q == IMP_LAST) begin
                            state_d = COOLDOWN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_i) begin
                        if (cnt_q == CD_LAST) begin
                            state_d = IDLE;
                            y_d     = SPAWN_Y;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = SPAWN_Y;
                end
            endcase
        end

        // Every phase starts counting frames from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        active_d = (state_d == FLYING);
        impact_d = (state_d == IMPACT);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= SPAWN_Y;
            cnt_q    <= '0;
            shots_q  <= '0;
            prev_q   <= 1'b1;
            fired_q  <= 1'b0;
            active_q <= 1'b0;
            impact_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            shots_q  <= shots_d;
            prev_q   <= shoot_i;
            fired_q  <= fired_d;
            active_q <= active_d;
            impact_q <= impact_d;
        end
    end

    assign bullet_active_o = active_q;
    assign impact_o        = impact_q;
    assign bullet_x_o      = x_q;
    assign bullet_y_o      = y_q;
    assign fired_o         = fired_q;
    assign shots_o         = shots_q;
    assign color_o         = color_p;
    assign state_o         = state_q;

endmodule

// File: tb/tb_player_bullet.sv
// Randomised + directed bench for player_bullet against a phase/timer reference model.
// Build with +define+PLAYER_BULLET_AUTOFIRE_EN to exercise the autofire variant.
module tb_player_bullet;

    logic        clk;
    logic        reset_i;
    logic        frame_i;
    logic        enable_i;
    logic        shoot_i;
    logic [9:0]  player_left_i;
    logic [9:0]  player_right_i;
    logic        hit_i;
    logic        bullet_active_o;
    logic        impact_o;
    logic [9:0]  bullet_x_o;
    logic [9:0]  bullet_y_o;
    logic        fired_o;
    logic [7:0]  shots_o;
    logic [11:0] color_o;
    logic [3:0]  state_o;

    player_bullet dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .frame_i         (frame_i),
        .enable_i        (enable_i),
        .shoot_i         (shoot_i),
        .player_left_i   (player_left_i),
        .player_right_i  (player_right_i),
        .hit_i           (hit_i),
        .bullet_active_o (bullet_active_o),
        .impact_o        (impact_o),
        .bullet_x_o      (bullet_x_o),
        .bullet_y_o      (bullet_y_o),
        .fired_o         (fired_o),
        .shots_o         (shots_o),
        .color_o         (color_o),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 flying, 2 impact, 3 cooldown; timer counts frames in phase.
    int m_phase = 0;
    int m_x     = 0;
    int m_y     = 440;
    int m_timer = 0;
    int m_shots = 0;
    int m_prev  = 1;
    int m_fired = 0;

    logic g_rst = 1'b1;
    logic g_en  = 1'b1;
    int   g_l   = 0;
    int   g_r   = 0;
    int   n_fired = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rst, en, sh, fr, ht, input int l, r);
        int old_phase;
        bit launch;
        if (!rst) begin
            m_phase = 0; m_x = 0; m_y = 440; m_timer = 0;
            m_shots = 0; m_prev = 1; m_fired = 0;
            return;
        end
`ifdef PLAYER_BULLET_AUTOFIRE_EN
        launch = sh;
`else
        launch = sh && (m_prev == 0);
`endif
        m_fired   = 0;
        old_phase = m_phase;
        if (!en) begin
            m_phase = 0;
            m_y     = 440;
        end else if (m_phase == 0) begin
            if (launch) begin
                m_phase = 1;
                m_x     = (l + r) / 2;
                m_y     = 440;
                m_fired = 1;
                if (m_shots < 255) m_shots++;
            end
        end else if (m_phase == 1) begin
            if (ht) m_phase = 2;
            else if (fr) begin
                if (m_y < 16 + 8) m_phase = 3;
                else m_y -= 8;
            end
        end else if (m_phase == 2) begin
            if (fr) begin
                m_timer++;
                if (m_timer == 4) m_phase = 3;
            end
        end else begin
            if (fr) begin
                m_timer++;
                if (m_timer == 2) begin
                    m_phase = 0;
                    m_y     = 440;
                end
            end
        end
        if (m_phase != old_phase) m_timer = 0;
        m_prev = sh ? 1 : 0;
    endtask

    // Drive one cycle, advance the model, and compare every output after the edge.
    task automatic tick(input logic sh, fr, ht);
        reset_i        = g_rst;
        enable_i       = g_en;
        shoot_i        = sh;
        frame_i        = fr;
        hit_i          = ht;
        player_left_i  = 10'(g_l);
        player_right_i = 10'(g_r);
        model_update(g_rst, g_en, sh, fr, ht, g_l, g_r);
        @(posedge clk);
        #1;
        if (fired_o === 1'b1) n_fired++;
        chk("state",  32'(state_o),         32'(4'b0001 << m_phase));
        chk("active", 32'(bullet_active_o), 32'(m_phase == 1));
        chk("impact", 32'(impact_o),        32'(m_phase == 2));
        chk("x",      32'(bullet_x_o),      32'(m_x));
        chk("y",      32'(bullet_y_o),      32'(m_y));
        chk("fired",  32'(fired_o),         32'(m_fired));
        chk("shots",  32'(shots_o),         32'(m_shots));
        chk("color",  32'(color_o),         32'hFF0);
    endtask

    task automatic frames(input int n, input logic sh);
        for (int i = 0; i < n; i++) begin
            tick(sh, 1'b1, 1'b0);
            tick(sh, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic sh;
        logic fr;
        logic ht;
        reset_i = 1'b0; enable_i = 1'b1; shoot_i = 1'b1; frame_i = 1'b0;
        hit_i = 1'b0; player_left_i = '0; player_right_i = '0;
        #1;

`ifndef PLAYER_BULLET_AUTOFIRE_EN
        // Button held through reset must not fire.
        g_rst = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("reset_state", 32'(state_o), 32'h1);
        chk("reset_y",     32'(bullet_y_o), 32'd440);
        chk("reset_shots", 32'(shots_o), 32'd0);
        g_rst = 1'b1;
        repeat (10) tick(1'b1, 1'b0, 1'b0);
        chk("held_no_fire", 32'(state_o), 32'h1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk("first_fire", 32'(fired_o), 32'd1);
        chk("first_shots", 32'(shots_o), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("fired_pulse", 32'(fired_o), 32'd0);
        g_en = 1'b0; tick(1'b0, 1'b0, 1'b0); g_en = 1'b1;

        // Full miss trajectory from the ship centre.
        g_l = 300; g_r = 331;
        tick(1'b1, 1'b0, 1'b0);
        chk("launch_x", 32'(bullet_x_o), 32'd315);
        chk("launch_y", 32'(bullet_y_o), 32'd440);
        tick(1'b0, 1'b0, 1'b0);
        g_l = 10; g_r = 20;
        frames(53, 1'b0);
        chk("top_y", 32'(bullet_y_o), 32'd16);
        chk("top_active", 32'(bullet_active_o), 32'd1);
        chk("x_fixed", 32'(bullet_x_o), 32'd315);
        frames(1, 1'b0);
        chk("miss_state", 32'(state_o), 32'h8);
        chk("miss_active", 32'(bullet_active_o), 32'd0);
        frames(2, 1'b0);
        chk("back_idle", 32'(state_o), 32'h1);

        // Hit and frame together: hit wins; presses in impact/cooldown ignored.
        tick(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
        frames(5, 1'b0);
        chk("y_400", 32'(bullet_y_o), 32'd400);
        tick(1'b0, 1'b1, 1'b1);
        chk("hit_impact", 32'(impact_o), 32'd1);
        chk("hit_y", 32'(bullet_y_o), 32'd400);
        tick(1'b1, 1'b0, 1'b0);
        chk("impact_press", 32'(fired_o), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        frames(3, 1'b0);
        chk("impact_hold", 32'(state_o), 32'h4);
        frames(1, 1'b0);
        chk("impact_done", 32'(state_o), 32'h8);
        tick(1'b1, 1'b0, 1'b0);
        chk("cool_press", 32'(fired_o), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        frames(2, 1'b0);
        chk("cool_done", 32'(state_o), 32'h1);
        chk("shots_3", 32'(shots_o), 32'd3);

        // Disable mid-flight.
        tick(1'b1, 1'b0, 1'b0); tick(1'b0, 1'b0, 1'b0);
        frames(3, 1'b0);
        g_en = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("dis_state", 32'(state_o), 32'h1);
        chk("dis_y", 32'(bullet_y_o), 32'd440);
        chk("dis_active", 32'(bullet_active_o), 32'd0);
        chk("dis_shots", 32'(shots_o), 32'd4);
        g_en = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        chk("reen_fire", 32'(fired_o), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        frames(6, 1'b0);

        // Saturation of the shot counter.
        for (int k = 0; k < 260; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b1);
            frames(6, 1'b0);
        end
        chk("shots_sat", 32'(shots_o), 32'd255);
`else
        // Autofire: held button refires at each return to IDLE.
        g_rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        g_rst = 1'b1;
        g_l = 100; g_r = 200;
        n_fired = 0;
        frames(3 * 56 + 2, 1'b1);
        chk("autofire_refire", 32'(n_fired >= 3), 32'd1);
        chk("autofire_shots", 32'(shots_o), 32'(n_fired));
`endif

        // Randomised traffic checked cycle by cycle against the model.
        sh = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            g_rst = ($urandom_range(0, 299) != 0);
            g_en  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) sh = ~sh;
            fr = ($urandom_range(0, 3) == 0);
            ht = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 15) == 0) begin
                g_l = int'($urandom_range(0, 1023));
                g_r = int'($urandom_range(0, 1023));
            end
            tick(sh, fr, ht);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
